// File: rtl/game_state_sequencer.sv
// Scene sequencer for the frame drawer: counts VGA frames and walks
// START -> FLASH -> FADE -> MAIN <-> HOLD from frame counts and key presses.
module game_state_sequencer #(
    parameter int         START_FRAMES = 60,
    parameter int         FLASH_PERIOD = 30,
    parameter int         FADE_FRAMES  = 52,
    parameter logic [7:0] KEY_ENTER    = 8'h28,
    parameter logic [7:0] KEY_ESC      = 8'h29
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       VGA_VS,
    input  logic [7:0] keycode,
    output logic [3:0] state_num,
    output logic       flash_on,
    output logic       frame_tick,
    output logic [7:0] frame_count,
    output logic       game_active
);
    typedef enum logic [3:0] {
        ST_START = 4'd0,
        ST_FLASH = 4'd1,
        ST_FADE  = 4'd2,
        ST_MAIN  = 4'd3,
        ST_HOLD  = 4'd4
    } state_t;

    localparam logic [7:0] START_LAST = 8'(START_FRAMES - 1);
    localparam logic [7:0] FLASH_LEN  = 8'(FLASH_PERIOD);
    localparam logic [7:0] FLASH_LAST = 8'(FLASH_PERIOD - 1);
    localparam logic [7:0] FADE_LAST  = 8'(FADE_FRAMES - 1);

    // [0] and [1] form the synchronizer, [2] delays [1] for edge detection
    logic [2:0] vs_sync_reg;
    logic [7:0] key_prev_reg;
    state_t     state_reg;
    logic [7:0] frame_count_reg;
    logic       flash_on_reg;
    logic       enter_press;
    logic       esc_press;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_sync_reg  <= 3'b000;
            key_prev_reg <= 8'h00;
        end else begin
            vs_sync_reg  <= {vs_sync_reg[1:0], VGA_VS};
            key_prev_reg <= keycode;
        end
    end

    assign frame_tick  = vs_sync_reg[1] & ~vs_sync_reg[2];
    assign enter_press = (keycode == KEY_ENTER) && (key_prev_reg != KEY_ENTER);
    assign esc_press   = (keycode == KEY_ESC) && (key_prev_reg != KEY_ESC);

    // A transition always wins over a count or blink toggle in the same cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg       <= ST_START;
            frame_count_reg <= 8'd0;
            flash_on_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_START: begin
                    flash_on_reg <= 1'b0;
                    if (frame_tick && frame_count_reg == START_LAST) begin
                        state_reg       <= ST_FLASH;
                        frame_count_reg <= 8'd0;
                        flash_on_reg    <= 1'b1;
                    end else if (frame_tick) begin
                        frame_count_reg <= frame_count_reg + 8'd1;
                    end
                end
                ST_FLASH: begin
                    if (enter_press) begin
                        state_reg       <= ST_FADE;
                        frame_count_reg <= 8'd0;
                        flash_on_reg    <= 1'b0;
                    end else if (frame_tick) begin
                        frame_count_reg <= frame_count_reg + 8'd1;
                        if ((frame_count_reg % FLASH_LEN) == FLASH_LAST) begin
                            flash_on_reg <= ~flash_on_reg;
                        end
                    end
                end
                ST_FADE: begin
                    flash_on_reg <= 1'b0;
                    if (frame_tick && frame_count_reg == FADE_LAST) begin
                        state_reg       <= ST_MAIN;
                        frame_count_reg <= 8'd0;
                    end else if (frame_tick) begin
                        frame_count_reg <= frame_count_reg + 8'd1;
                    end
                end
                ST_MAIN, ST_HOLD: begin
                    flash_on_reg <= 1'b0;
                    if (esc_press) begin
                        state_reg       <= (state_reg == ST_MAIN) ? ST_HOLD : ST_MAIN;
                        frame_count_reg <= 8'd0;
                    end else if (frame_tick && frame_count_reg != 8'hFF) begin
                        frame_count_reg <= frame_count_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg       <= ST_START;
                    frame_count_reg <= 8'd0;
                    flash_on_reg    <= 1'b0;
                end
            endcase
        end
    end

    assign state_num   = state_reg;
    assign flash_on    = flash_on_reg;
    assign frame_count = frame_count_reg;
    assign game_active = (state_reg == ST_MAIN);

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed bench for game_state_sequencer: a scene-level model is checked
// against the DUT every cycle, plus hand-computed literal checkpoints.
module tb_game_state_sequencer;
    localparam int SF = 3;
    localparam int FP = 2;
    localparam int FF = 52;
    localparam int K_ENTER = 8'h28;
    localparam int K_ESC   = 8'h29;

    logic       clk;
    logic       Reset;
    logic       VGA_VS;
    logic [7:0] keycode;
    logic [3:0] state_num;
    logic       flash_on;
    logic       frame_tick;
    logic [7:0] frame_count;
    logic       game_active;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    game_state_sequencer #(
        .START_FRAMES(SF),
        .FLASH_PERIOD(FP),
        .FADE_FRAMES (FF),
        .KEY_ENTER   (8'h28),
        .KEY_ESC     (8'h29)
    ) dut (
        .Clk        (clk),
        .Reset      (Reset),
        .VGA_VS     (VGA_VS),
        .keycode    (keycode),
        .state_num  (state_num),
        .flash_on   (flash_on),
        .frame_tick (frame_tick),
        .frame_count(frame_count),
        .game_active(game_active)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scene-level model: scene number, unbounded frame count, key history,
    // and a record of VGA_VS as seen on the last three edges.
    int m_scene = 0;
    int m_cnt   = 0;
    int m_prev  = 0;
    bit v1 = 0, v2 = 0, v3 = 0;

    always @(posedge clk) begin
        bit tick, enter, esc;
        int nxt;
        if (Reset) begin
            m_scene = 0; m_cnt = 0; m_prev = 0;
            v1 = 0; v2 = 0; v3 = 0;
        end else begin
            tick  = v2 && !v3;
            enter = (int'(keycode) == K_ENTER) && (m_prev != K_ENTER);
            esc   = (int'(keycode) == K_ESC) && (m_prev != K_ESC);
            nxt   = m_scene;
            case (m_scene)
                0: if (tick && m_cnt == SF - 1) nxt = 1;
                1: if (enter) nxt = 2;
                2: if (tick && m_cnt == FF - 1) nxt = 3;
                3: if (esc) nxt = 4;
                4: if (esc) nxt = 3;
                default: nxt = 0;
            endcase
            if (nxt != m_scene) begin
                m_scene = nxt;
                m_cnt   = 0;
            end else if (tick) begin
                m_cnt++;
            end
            m_prev = int'(keycode);
            v3 = v2; v2 = v1; v1 = VGA_VS;
        end
    end

    function automatic int exp_count();
        if (m_scene >= 3) return (m_cnt > 255) ? 255 : m_cnt;
        return m_cnt % 256;
    endfunction

    function automatic int exp_flash();
        if (m_scene != 1) return 0;
        return (((m_cnt % 256) / FP) % 2 == 0) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_state", 32'(state_num), 32'(m_scene));
            check("model_count", 32'(frame_count), 32'(exp_count()));
            check("model_flash", 32'(flash_on), 32'(exp_flash()));
            check("model_tick", 32'(frame_tick), 32'(v2 && !v3));
            check("model_active", 32'(game_active), 32'(m_scene == 3));
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vs_pulse();
        VGA_VS = 1'b1;
        cycles(2);
        VGA_VS = 1'b0;
        cycles(4);
        $display("vs pulse: state=%0d count=%0d flash=%0d", state_num, frame_count, flash_on);
    endtask

    task automatic key_tap(input logic [7:0] k);
        keycode = k;
        cycles(1);
        keycode = 8'h00;
        $display("key 0x%02h: state=%0d count=%0d", k, state_num, frame_count);
    endtask

    initial begin
        repeat (100000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int flash_seq[6] = '{1, 0, 0, 1, 1, 0};
        Reset = 1'b1; VGA_VS = 1'b0; keycode = 8'h00;
        cycles(2);
        chk_en = 1;
        check("rst_state", 32'(state_num), 0);
        check("rst_flash", 32'(flash_on), 0);
        check("rst_count", 32'(frame_count), 0);
        check("rst_tick", 32'(frame_tick), 0);
        check("rst_active", 32'(game_active), 0);
        Reset = 1'b0;
        cycles(1);

        vs_pulse();
        vs_pulse();
        check("start_state", 32'(state_num), 0);
        check("start_count", 32'(frame_count), 2);
        vs_pulse();
        check("enter_flash_state", 32'(state_num), 1);
        check("enter_flash_on", 32'(flash_on), 1);
        check("enter_flash_count", 32'(frame_count), 0);

        for (int i = 0; i < 6; i++) begin
            vs_pulse();
            check("blink", 32'(flash_on), 32'(flash_seq[i]));
        end

        keycode = 8'h28;
        cycles(10);
        check("enter_held_state", 32'(state_num), 2);
        check("enter_held_flash", 32'(flash_on), 0);
        keycode = 8'h00;
        cycles(1);

        for (int i = 0; i < FF; i++) begin
            key_tap((i % 3 == 0) ? 8'h28 : (i % 3 == 1) ? 8'h29 : 8'h00);
            vs_pulse();
            if (i == FF - 2) begin
                check("fade_hold_state", 32'(state_num), 2);
                check("fade_hold_count", 32'(frame_count), 51);
            end
        end
        check("main_state", 32'(state_num), 3);
        check("main_active", 32'(game_active), 1);
        check("main_count", 32'(frame_count), 0);

        keycode = 8'h29;
        cycles(1);
        check("esc_to_hold", 32'(state_num), 4);
        check("hold_inactive", 32'(game_active), 0);
        cycles(5);
        check("esc_held_hold", 32'(state_num), 4);
        keycode = 8'h00;
        cycles(2);
        key_tap(8'h29);
        check("esc_to_main", 32'(state_num), 3);
        cycles(1);
        key_tap(8'h29);
        check("esc_back_hold", 32'(state_num), 4);

        for (int i = 0; i < 300; i++) vs_pulse();
        check("hold_sat_count", 32'(frame_count), 255);
        check("hold_sat_state", 32'(state_num), 4);

        key_tap(8'h29);
        check("main_again", 32'(state_num), 3);

        VGA_VS = 1'b1;
        cycles(1);
        Reset = 1'b1;
        cycles(1);
        check("midrst_state", 32'(state_num), 0);
        check("midrst_count", 32'(frame_count), 0);
        check("midrst_flash", 32'(flash_on), 0);
        check("midrst_tick", 32'(frame_tick), 0);
        check("midrst_active", 32'(game_active), 0);
        Reset = 1'b0;
        VGA_VS = 1'b0;
        cycles(4);
        check("postrst_count0", 32'(frame_count), 0);
        vs_pulse();
        check("postrst_state", 32'(state_num), 0);
        check("postrst_count1", 32'(frame_count), 1);

        vs_pulse();
        vs_pulse();
        check("reflash_state", 32'(state_num), 1);
        vs_pulse();
        check("reflash_count", 32'(frame_count), 1);
        check("reflash_on", 32'(flash_on), 1);

        // Enter lands on the same edge as a toggle-due tick
        VGA_VS = 1'b1;
        cycles(2);
        keycode = 8'h28;
        VGA_VS = 1'b0;
        cycles(1);
        check("coinc_state", 32'(state_num), 2);
        check("coinc_count", 32'(frame_count), 0);
        check("coinc_flash", 32'(flash_on), 0);
        $display("coincident enter+tick: state=%0d count=%0d flash=%0d", state_num, frame_count, flash_on);
        keycode = 8'h00;
        cycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_state_sequencer.md
# game_state_sequencer

Top-level scene sequencer for the frame drawer. It produces the `state_num` code that selects what the drawer writes into the framebuffer each frame. It counts video frames, derived from `VGA_VS`, and walks the scene sequence: title hold, flashing "press enter" prompt, fade-out, main game, pause. Transitions come from frame counts and keyboard press events. It sits between the USB keyboard interface and `frameDrawer`, in the `Clk` domain.

## Interface
Parameters:
- `START_FRAMES`, 60: frames spent in START before moving to FLASH (1..255).
- `FLASH_PERIOD`, 30: frames per half-period of the prompt blink (1..255).
- `FADE_FRAMES`, 52: frames spent in FADE; 52 × 5 ≥ 255 guarantees black (1..255).
- `KEY_ENTER`, 8'h28: keycode that advances FLASH → FADE.
- `KEY_ESC`, 8'h29: keycode that toggles MAIN ↔ HOLD.

Ports:
- `Clk`, in, 1: system clock; all logic is clocked on the rising edge.
- `Reset`, in, 1: synchronous, active-high.
- `VGA_VS`, in, 1: vertical sync, asynchronous to `Clk`; its rising edge marks a new frame.
- `keycode`, in, 8: current keyboard code, synchronous to `Clk`; 8'h00 means no key.
- `state_num`, out, 4: scene code. 0 START, 1 FLASH, 2 FADE, 3 MAIN, 4 HOLD.
- `flash_on`, out, 1: prompt-visible phase; high only in FLASH.
- `frame_tick`, out, 1: one-cycle pulse per detected frame.
- `frame_count`, out, 8: frames counted since the last state entry.
- `game_active`, out, 1: high iff `state_num` == 3.

## Operation
- Frame detection:
  - `VGA_VS` passes through two synchronizer flops (s1, s2) and then a delay flop (s3).
  - `frame_tick` = s2 & ~s3, registered-path combinational.
  - Exactly one pulse per `VGA_VS` rising edge.
- Key events:
  - `key_prev` registers `keycode` every cycle.
  - enter_press = (`keycode` == KEY_ENTER) && (`key_prev` != KEY_ENTER); esc_press is defined the same way with KEY_ESC.
  - A held key produces exactly one event.
- `frame_count` (8-bit):
  - Increments on `frame_tick`.
  - Clears to 0 on every state transition.
  - Saturates at 255 in MAIN and HOLD; never wraps.
- State machine, with registered state. Each transition takes effect on the clock edge where its condition is true:
  - START: when `frame_tick` arrives with `frame_count` == START_FRAMES−1, go to FLASH. Keys are ignored.
  - FLASH: on enter_press, go to FADE. While in FLASH, on a `frame_tick` where `frame_count` mod FLASH_PERIOD == FLASH_PERIOD−1, toggle `flash_on`.
  - FADE: when `frame_tick` arrives with `frame_count` == FADE_FRAMES−1, go to MAIN. Keys are ignored.
  - MAIN: on esc_press, go to HOLD.
  - HOLD: on esc_press, go to MAIN. `frame_count` keeps counting.
- `flash_on` behaviour:
  - Set to 1 on the edge that enters FLASH.
  - Forced to 0 on the edge that leaves FLASH, and in every other state.
- Simultaneous events:
  - A transition has priority over a count or toggle in the same cycle. The counter clears and is not incremented; the `flash_on` toggle is suppressed.
  - The FLASH blink counter is `frame_count` mod FLASH_PERIOD. `frame_count` wraps 255→0 only in FLASH; there the blink phase may skip at the wrap, which is acceptable.
- Unused codes 5..15 cannot be reached. If the state register ever holds one, the next state is START.

## Timing
- Reset values:
  - `state_num` = 0, `flash_on` = 0, `frame_count` = 0, `frame_tick` = 0, `game_active` = 0.
  - `key_prev` = 8'h00; s1, s2 and s3 = 0.
- Reset asserted mid-operation returns everything to the reset values on the next edge. No tick or press is acted on while `Reset` is high.
- Latency from a `VGA_VS` rising edge to `frame_tick` is 2–3 `Clk` cycles, depending on synchronizer sampling.
- Latency from `keycode` changing to KEY_ENTER until `state_num` = 2 is 1 cycle: the state register updates on the first edge that sees the new keycode.
- All outputs are registered except `frame_tick`, which is a function of flops only, and `game_active`, which is a decode of the state register.
- `state_num` changes at most once per cycle and is stable between edges. `frameDrawer` samples it on its own `VGA_VS`, so the sequencer does not try to align transitions to blanking.

## Test plan
- Reset, then START_FRAMES=3 with 3 `VGA_VS` pulses → `state_num` 0→1 on the 3rd `frame_tick`, `flash_on`=1, `frame_count`=0.
- In FLASH with FLASH_PERIOD=2, send 6 ticks → `flash_on` sequence 1,1,0,0,1,1,0. Then hold `keycode`=8'h28 for 10 cycles → exactly one transition to 2, and `flash_on`=0.
- In FADE with FADE_FRAMES=52, press Enter and Esc repeatedly → no change; after 52 ticks, `state_num`=3 and `game_active`=1.
- In MAIN, Esc press → 4; Esc held → stays 4; release then press → 3. Run 300 ticks in HOLD → `frame_count` saturates at 255.
- In FLASH, an Enter press in the same cycle as a toggle-due `frame_tick` → `state_num`=2, `frame_count`=0, `flash_on`=0.
- In MAIN, assert `Reset` for one cycle during a `VGA_VS` pulse → all outputs at reset values; the next tick counts from 0 in START.
